// File: rtl/rr_merge_pkg.sv
// Shared channel-protocol definitions for the merge/arbiter slice.
// Holds bp polarity, the transfer rule and index-width helpers.
package rr_merge_pkg;

  localparam logic BP_STALL = 1'b1;
  localparam logic BP_GO    = 1'b0;

  function automatic logic xfer(
    input logic valid,
    input logic bp
  );
    return valid && (bp == BP_GO);
  endfunction

  function automatic int clog2(input int n);
    for (int r = 0; r < 31; r++) begin
      if ((1 << r) >= n) return r;
    end
    return 31;
  endfunction

  function automatic int sel_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first req at or after ptr, wrapping.
// Ports: req, ptr in; gnt_valid, gnt_idx out.
module rr_arbiter
  import rr_merge_pkg::*;
#(
  parameter int NumInputs = 4
) (
  input  logic [NumInputs-1:0]            req,
  input  logic [sel_width(NumInputs)-1:0] ptr,
  output logic                            gnt_valid,
  output logic [sel_width(NumInputs)-1:0] gnt_idx
);

  localparam int SW = sel_width(NumInputs);

  logic [SW-1:0] idx;

  // Scan from the farthest offset down so the
  // closest requester to ptr wins last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = NumInputs - 1; k >= 0; k--) begin
      idx = SW'((int'(ptr) + k) % NumInputs);
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/rr_merge.sv
// N-to-1 round-robin merge into one registered valid/bp output.
// Ports: clk, resetn, din/din_valid/din_bp in; dout/dout_src/dout_valid/dout_bp out.
module rr_merge
  import rr_merge_pkg::*;
#(
  parameter int Width     = 8,
  parameter int NumInputs = 4
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic [NumInputs*Width-1:0]      din,
  input  logic [NumInputs-1:0]            din_valid,
  output logic [NumInputs-1:0]            din_bp,
  output logic [Width-1:0]                dout,
  output logic [sel_width(NumInputs)-1:0] dout_src,
  output logic                            dout_valid,
  input  logic                            dout_bp
);

  localparam int SelWidth = sel_width(NumInputs);
  localparam logic [SelWidth-1:0] LastIdx =
    SelWidth'(NumInputs - 1);

  logic [SelWidth-1:0] ptr;
  logic [SelWidth-1:0] ptr_next;
  logic [SelWidth-1:0] gnt_idx;
  logic                gnt_valid;
  logic                can_load;
  logic                accept;
  logic [Width-1:0]    sel_data;

  rr_arbiter #(
    .NumInputs(NumInputs)
  ) u_arb (
    .req      (din_valid),
    .ptr      (ptr),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  // Empty, or draining this cycle: a load can
  // overlap the drain with no bubble.
  assign can_load = !dout_valid || (dout_bp == BP_GO);
  assign accept   = gnt_valid && can_load && resetn;

  // Explicit wrap keeps non-power-of-2 counts correct.
  assign ptr_next = (gnt_idx == LastIdx) ?
                    '0 : gnt_idx + 1'b1;

  always_comb begin
    din_bp   = {NumInputs{BP_STALL}};
    sel_data = '0;
    for (int i = 0; i < NumInputs; i++) begin
      if (gnt_idx == SelWidth'(i)) begin
        sel_data = din[i*Width +: Width];
        if (accept) din_bp[i] = BP_GO;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dout       <= '0;
      dout_src   <= '0;
      dout_valid <= 1'b0;
      ptr        <= '0;
    end else if (accept) begin
      dout       <= sel_data;
      dout_src   <= gnt_idx;
      dout_valid <= 1'b1;
      ptr        <= ptr_next;
    end else if (xfer(dout_valid, dout_bp)) begin
      dout_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_merge.sv
// Self-checking bench for rr_merge (N=4 and N=3 instances).
// Queue-free reference model plus directed literal checks.
module tb_rr_merge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic [31:0] d4;
  logic [3:0]  v4, bp4;
  logic [7:0]  o4;
  logic [1:0]  s4;
  logic        ov4, obp4;

  logic [23:0] d3;
  logic [2:0]  v3, bp3;
  logic [7:0]  o3;
  logic [1:0]  s3;
  logic        ov3, obp3;

  rr_merge #(.Width(8), .NumInputs(4)) u4 (
    .clk(clk), .resetn(resetn),
    .din(d4), .din_valid(v4), .din_bp(bp4),
    .dout(o4), .dout_src(s4), .dout_valid(ov4),
    .dout_bp(obp4)
  );

  rr_merge #(.Width(8), .NumInputs(3)) u3 (
    .clk(clk), .resetn(resetn),
    .din(d3), .din_valid(v3), .din_bp(bp3),
    .dout(o3), .dout_src(s3), .dout_valid(ov3),
    .dout_bp(obp3)
  );

  int passed = 0;
  int total  = 0;
  bit cmp_en = 1'b0;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    else
      passed++;
  endtask

  // Reference model: one entry per instance.
  logic       mv [2];
  logic [7:0] md [2];
  int         ms [2];
  int         mp [2];

  function automatic int n_of(input int id);
    return (id == 0) ? 4 : 3;
  endfunction

  function automatic logic [3:0] vin(input int id);
    return (id == 0) ? v4 : {1'b0, v3};
  endfunction

  function automatic logic bpin(input int id);
    return (id == 0) ? obp4 : obp3;
  endfunction

  function automatic logic [7:0] dsel(
    input int id, input int g
  );
    return (id == 0) ? d4[g*8 +: 8] : d3[g*8 +: 8];
  endfunction

  function automatic int pick(
    input logic [3:0] v, input int p, input int n
  );
    for (int k = 0; k < n; k++)
      if (v[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction

  function automatic logic [3:0] exp_bp(input int id);
    logic [3:0] r;
    int g;
    logic acc;
    g   = pick(vin(id), mp[id], n_of(id));
    acc = resetn && (g >= 0) && (!mv[id] || !bpin(id));
    r   = '0;
    for (int i = 0; i < n_of(id); i++)
      r[i] = !(acc && g == i);
    return r;
  endfunction

  always @(posedge clk) begin
    for (int id = 0; id < 2; id++) begin
      int g;
      g = pick(vin(id), mp[id], n_of(id));
      if (!resetn) begin
        mv[id] = 1'b0; md[id] = '0;
        ms[id] = 0;    mp[id] = 0;
      end else if (g >= 0 && (!mv[id] || !bpin(id))) begin
        md[id] = dsel(id, g);
        ms[id] = g;
        mv[id] = 1'b1;
        mp[id] = (g + 1) % n_of(id);
      end else if (mv[id] && !bpin(id)) begin
        mv[id] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m4.valid", ov4, mv[0]);
      chk("m4.dout", o4, md[0]);
      chk("m4.src", s4, ms[0]);
      chk("m4.ptr", u4.ptr, mp[0]);
      chk("m4.din_bp", bp4, exp_bp(0));
      chk("m3.valid", ov3, mv[1]);
      chk("m3.dout", o3, md[1]);
      chk("m3.src", s3, ms[1]);
      chk("m3.ptr", u3.ptr, mp[1]);
      chk("m3.din_bp", {1'b0, bp3}, exp_bp(1));
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] e;
    resetn = 1'b0;
    v4 = '0; v3 = '0; obp4 = 1'b0; obp3 = 1'b0;
    d4 = 32'h33323130;
    d3 = 24'h525150;
    cyc;
    cmp_en = 1'b1;
    chk("rst valid", ov4, 0);
    chk("rst dout", o4, 0);
    chk("rst src", s4, 0);
    chk("rst din_bp", bp4, 4'hF);

    // Fairness: all valid, no backpressure.
    resetn = 1'b1;
    v4 = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      e = ~(4'b0001 << (k % 4));
      chk("fair din_bp", bp4, e);
      cyc;
      chk("fair src", s4, k % 4);
      chk("fair valid", ov4, 1);
      chk("fair dout", o4, 8'h30 + 8'(k % 4));
    end

    // Single input.
    v4 = 4'b0001;
    d4[7:0] = 8'hA5;
    #1;
    chk("single din_bp", bp4, 4'b1110);
    cyc;
    chk("single dout", o4, 8'hA5);
    chk("single src", s4, 0);
    chk("single valid", ov4, 1);
    chk("single ptr", u4.ptr, 1);
    chk("model ptr", mp[0], 1);
    v4 = '0;

    // Idle drain.
    #1;
    chk("idle din_bp", bp4, 4'hF);
    cyc;
    chk("drain valid", ov4, 0);
    chk("drain dout", o4, 8'hA5);
    chk("drain src", s4, 0);

    // Backpressure hold then drain+load.
    v4 = 4'b0100;
    d4[23:16] = 8'h11;
    cyc;
    chk("bp load", o4, 8'h11);
    chk("bp ptr", u4.ptr, 3);
    obp4 = 1'b1;
    v4 = 4'b1011;
    d4[7:0] = 8'h20; d4[15:8] = 8'h21;
    d4[31:24] = 8'h23;
    repeat (3) begin
      #1;
      chk("stall din_bp", bp4, 4'hF);
      chk("stall dout", o4, 8'h11);
      chk("stall src", s4, 2);
      chk("stall valid", ov4, 1);
      chk("stall ptr", u4.ptr, 3);
      cyc;
    end
    chk("held dout", o4, 8'h11);
    obp4 = 1'b0;
    #1;
    chk("release din_bp", bp4, 4'b0111);
    cyc;
    chk("release dout", o4, 8'h23);
    chk("release src", s4, 3);
    chk("release valid", ov4, 1);
    chk("release ptr", u4.ptr, 0);
    v4 = 4'b0011;

    // Reset while stalled with a full register.
    obp4 = 1'b1;
    resetn = 1'b0;
    #1;
    chk("rst2 din_bp", bp4, 4'hF);
    cyc;
    chk("rst2 valid", ov4, 0);
    chk("rst2 dout", o4, 0);
    chk("rst2 ptr", u4.ptr, 0);
    resetn = 1'b1;
    obp4 = 1'b0;

    // N=3 wrap and skip.
    v3 = 3'b010;
    cyc;
    chk("n3 first src", s3, 1);
    chk("n3 ptr2", u3.ptr, 2);
    v3 = 3'b011;
    #1;
    chk("n3 din_bp", bp3, 3'b110);
    cyc;
    chk("n3 wrap src", s3, 0);
    chk("n3 wrap dout", o3, 8'h50);
    chk("n3 wrap ptr", u3.ptr, 1);
    v3 = 3'b010;
    cyc;
    chk("n3 ptr again", u3.ptr, 2);
    v3 = 3'b100;
    cyc;
    chk("n3 last src", s3, 2);
    chk("n3 last dout", o3, 8'h52);
    chk("n3 last ptr", u3.ptr, 0);
    v3 = '0;
    v4 = '0;
    cyc;
    cyc;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
